// File: rtl/lpc_pkg.sv
// Shared LPC defaults, autocorrelation sequencer state type and R-bank select width helper.
package lpc_pkg;

    localparam int ORDER_DEF     = 10;
    localparam int FRAME_LEN_DEF = 240;
    localparam int ADDR_W_DEF    = 8;
    localparam int PIPE_LAT_DEF  = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_ACC,
        ST_DRAIN,
        ST_WRITE,
        ST_LEV,
        ST_WAIT,
        ST_DONE
    } ac_state_e;

    // One R register per lag 0..order.
    function automatic int sel_width(input int order);
        return order + 1;
    endfunction

endpackage

// File: rtl/autocorr_valid_pipe.sv
// Delays the address-issue strobe by PIPE_LAT cycles so mac_en lines up with RAM data + multiplier register.
module autocorr_valid_pipe #(
    parameter int PIPE_LAT = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic flush_i,
    input  logic valid_i,
    output logic valid_o
);

    logic [PIPE_LAT-1:0] pipe_q;
    logic [PIPE_LAT-1:0] pipe_d;

    always_comb begin
        pipe_d = '0;
        if (!flush_i) begin
            pipe_d[0] = valid_i;
            for (int unsigned i = 1; i < PIPE_LAT; i++) begin
                pipe_d[i] = pipe_q[i-1];
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pipe_q <= '0;
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign valid_o = pipe_q[PIPE_LAT-1];

endmodule

// File: rtl/autocorr_control.sv
// LPC autocorrelation sequencer: per-lag MAC addressing, R-bank write, Levinson kick-off.
// Optional AUTOCORR_ABORT_EN adds an abort input that returns the sequencer to IDLE.
module autocorr_control
    import lpc_pkg::*;
#(
    parameter int ORDER     = ORDER_DEF,
    parameter int FRAME_LEN = FRAME_LEN_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int PIPE_LAT  = PIPE_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              lev_ready,
`ifdef AUTOCORR_ABORT_EN
    input  logic              abort,
`endif
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] x_addr_a,
    output logic [ADDR_W-1:0] x_addr_b,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              r_we,
    output logic [ORDER:0]    r_wsel,
    output logic              lev_start
);

    localparam int SELW = sel_width(ORDER);
    localparam int KW   = (ORDER > 0) ? $clog2(ORDER + 1) : 1;
    localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [ADDR_W-1:0] N_MAX  = ADDR_W'(FRAME_LEN - 1);
    localparam logic [KW-1:0]     K_LAST = KW'(ORDER);
    localparam logic [DW-1:0]     D_LAST = DW'(PIPE_LAT - 1);

    ac_state_e         state_q;
    logic [KW-1:0]     k_q;
    logic [ADDR_W-1:0] n_q;
    logic [DW-1:0]     drain_q;
    logic              issue_q;
    logic              busy_q;
    logic              done_q;
    logic              mac_clr_q;
    logic              r_we_q;
    logic [SELW-1:0]   r_wsel_q;
    logic              lev_start_q;
    logic [ADDR_W-1:0] x_addr_a_q;
    logic [ADDR_W-1:0] x_addr_b_q;

    logic              abort_w;
    logic              flush_w;
    logic [ADDR_W-1:0] n_last;
    logic [ADDR_W-1:0] n_next;

`ifdef AUTOCORR_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    assign flush_w = abort_w && (state_q != ST_IDLE);
    assign n_last  = N_MAX - ADDR_W'(k_q);
    assign n_next  = n_q + ADDR_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            drain_q     <= '0;
            issue_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            r_we_q      <= 1'b0;
            r_wsel_q    <= '0;
            lev_start_q <= 1'b0;
            x_addr_a_q  <= '0;
            x_addr_b_q  <= '0;
        end else begin
            // Single-cycle strobes default low; each state raises what it needs for the next cycle.
            done_q      <= 1'b0;
            mac_clr_q   <= 1'b0;
            r_we_q      <= 1'b0;
            r_wsel_q    <= '0;
            lev_start_q <= 1'b0;

            if (flush_w) begin
                state_q <= ST_IDLE;
                issue_q <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            k_q       <= '0;
                            mac_clr_q <= 1'b1;
                            busy_q    <= 1'b1;
                            state_q   <= ST_CLR;
                        end
                    end
                    ST_CLR: begin
                        n_q        <= '0;
                        x_addr_a_q <= '0;
                        x_addr_b_q <= ADDR_W'(k_q);
                        issue_q    <= 1'b1;
                        state_q    <= ST_ACC;
                    end
                    ST_ACC: begin
                        if (n_q == n_last) begin
                            issue_q <= 1'b0;
                            drain_q <= '0;
                            state_q <= ST_DRAIN;
                        end else begin
                            n_q        <= n_next;
                            x_addr_a_q <= n_next;
                            x_addr_b_q <= n_next + ADDR_W'(k_q);
                        end
                    end
                    ST_DRAIN: begin
                        if (drain_q == D_LAST) begin
                            r_we_q   <= 1'b1;
                            r_wsel_q <= SELW'(1) << k_q;
                            state_q  <= ST_WRITE;
                        end else begin
                            drain_q <= drain_q + DW'(1);
                        end
                    end
                    ST_WRITE: begin
                        if (k_q == K_LAST) begin
                            lev_start_q <= 1'b1;
                            state_q     <= ST_LEV;
                        end else begin
                            k_q       <= k_q + KW'(1);
                            mac_clr_q <= 1'b1;
                            state_q   <= ST_CLR;
                        end
                    end
                    // lev_ready is not looked at here: the Levinson block is restarting this cycle.
                    ST_LEV: begin
                        state_q <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (lev_ready) begin
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        busy_q  <= 1'b0;
                        issue_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    autocorr_valid_pipe #(
        .PIPE_LAT (PIPE_LAT)
    ) u_valid_pipe (
        .clk_i   (clk),
        .rst_n_i (reset_n),
        .flush_i (flush_w),
        .valid_i (issue_q),
        .valid_o (mac_en)
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign mac_clr   = mac_clr_q;
    assign r_we      = r_we_q;
    assign r_wsel    = r_wsel_q;
    assign lev_start = lev_start_q;
    assign x_addr_a  = x_addr_a_q;
    assign x_addr_b  = x_addr_b_q;

endmodule

// File: tb/tb_autocorr_control.sv
// Self-checking bench for autocorr_control (small frame, randomized lev_ready/start/abort timing).
module tb_autocorr_control;

    localparam int ORDER     = 2;
    localparam int FRAME_LEN = 8;
    localparam int ADDR_W    = 4;
    localparam int PIPE_LAT  = 2;
    localparam int CW        = ORDER + 7;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic              lev_ready = 1'b0;
`ifdef AUTOCORR_ABORT_EN
    logic              abort = 1'b0;
`endif
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] x_addr_a;
    logic [ADDR_W-1:0] x_addr_b;
    logic              mac_clr;
    logic              mac_en;
    logic              r_we;
    logic [ORDER:0]    r_wsel;
    logic              lev_start;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    autocorr_control #(
        .ORDER     (ORDER),
        .FRAME_LEN (FRAME_LEN),
        .ADDR_W    (ADDR_W),
        .PIPE_LAT  (PIPE_LAT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .lev_ready (lev_ready),
`ifdef AUTOCORR_ABORT_EN
        .abort     (abort),
`endif
        .busy      (busy),
        .done      (done),
        .x_addr_a  (x_addr_a),
        .x_addr_b  (x_addr_b),
        .mac_clr   (mac_clr),
        .mac_en    (mac_en),
        .r_we      (r_we),
        .r_wsel    (r_wsel),
        .lev_start (lev_start)
    );

    // Cycle index (1 = first cycle after the start edge) at which lag k begins with its CLR cycle.
    function automatic int lag_base(input int k);
        int b;
        b = 1;
        for (int j = 0; j < k; j++) b += 1 + (FRAME_LEN - j) + PIPE_LAT + 1;
        return b;
    endfunction

    // Expected control vector {busy,mac_clr,mac_en,r_we,r_wsel,lev_start,done} and addresses at cycle c.
    function automatic void model(input int c, input int done_c, output logic [CW-1:0] ctl,
                                  output bit has_a, output int ea, output int eb);
        logic clr_e, en_e, we_e, lev_e, done_e, busy_e;
        logic [ORDER:0] wsel_e;
        clr_e = 0; en_e = 0; we_e = 0; wsel_e = '0; has_a = 0; ea = 0; eb = 0;
        for (int k = 0; k <= ORDER; k++) begin
            int b;
            int len;
            b   = lag_base(k);
            len = FRAME_LEN - k;
            if (c == b) clr_e = 1;
            if (c >= b + 1 && c <= b + len) begin has_a = 1; ea = c - b - 1; eb = ea + k; end
            if (c > b + len && c <= b + len + PIPE_LAT) begin has_a = 1; ea = len - 1; eb = FRAME_LEN - 1; end
            if (c >= b + 1 + PIPE_LAT && c <= b + len + PIPE_LAT) en_e = 1;
            if (c == b + len + PIPE_LAT + 1) begin we_e = 1; wsel_e[k] = 1'b1; end
        end
        lev_e  = (c == lag_base(ORDER + 1));
        done_e = (c == done_c);
        busy_e = (c >= 1 && c <= done_c);
        ctl = {busy_e, clr_e, en_e, we_e, wsel_e, lev_e, done_e};
    endfunction

    // Runs one whole frame from an IDLE point between edges; ready_delay < 0 holds lev_ready high throughout.
    task automatic run_frame(input int ready_delay, input bit hold_start, output int done_c);
        int lev_c, ready_from, en_cnt, en_exp, ea, eb, max_b;
        bit has_a;
        logic [CW-1:0] ctl_e, ctl_o;
        lev_c      = lag_base(ORDER + 1);
        ready_from = (ready_delay < 0) ? 0 : lev_c + ready_delay;
        done_c     = ((lev_c + 1 > ready_from) ? lev_c + 1 : ready_from) + 1;
        en_cnt = 0; en_exp = 0; max_b = 0;
        for (int k = 0; k <= ORDER; k++) en_exp += FRAME_LEN - k;
        start     = 1'b1;
        lev_ready = (ready_delay < 0);
        for (int c = 1; c <= done_c; c++) begin
            @(posedge clk); #1;
            start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
            if (ready_delay < 0)      lev_ready = 1'b1;
            else if (c <= lev_c)      lev_ready = 1'($urandom_range(0, 1));
            else                      lev_ready = (c >= ready_from);
            @(negedge clk);
            model(c, done_c, ctl_e, has_a, ea, eb);
            ctl_o = {busy, mac_clr, mac_en, r_we, r_wsel, lev_start, done};
            n_cmp++;
            if (ctl_o !== ctl_e) begin
                n_err++;
                $display("FAIL ctl cycle %0d: got %b want %b (busy,clr,en,we,wsel,lev,done)", c, ctl_o, ctl_e);
            end
            if (has_a) begin
                n_cmp++;
                if (x_addr_a !== ADDR_W'(ea) || x_addr_b !== ADDR_W'(eb)) begin
                    n_err++;
                    $display("FAIL addr cycle %0d: got (%0d,%0d) want (%0d,%0d)", c, x_addr_a, x_addr_b, ea, eb);
                end
            end
            if (mac_en === 1'b1) en_cnt++;
            if (int'(x_addr_b) > max_b) max_b = int'(x_addr_b);
        end
        n_cmp++;
        if (en_cnt != en_exp) begin
            n_err++;
            $display("FAIL mac_en_count: got %0d want %0d", en_cnt, en_exp);
        end
        n_cmp++;
        if (max_b > FRAME_LEN - 1) begin
            n_err++;
            $display("FAIL addr_b_range: got max %0d want <= %0d", max_b, FRAME_LEN - 1);
        end
    endtask

    task automatic check_idle(input string tag);
        n_cmp++;
        if ({busy, done, r_we, lev_start, mac_en} !== 5'b0) begin
            n_err++;
            $display("FAIL %s: got busy/done/we/lev/en=%b want 00000", tag, {busy, done, r_we, lev_start, mac_en});
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        n_cmp++;
        if ({busy, done, mac_clr, mac_en, r_we, r_wsel, lev_start, x_addr_a, x_addr_b} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {busy, done, mac_clr, mac_en, r_we, r_wsel, lev_start, x_addr_a, x_addr_b});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("idle_after_reset");
    endtask

    task automatic test_frame_basic();
        int dc;
        run_frame(int'($urandom_range(1, 6)), 1'b0, dc);
        @(posedge clk); #1;
        start = 1'b0; lev_ready = 1'b0;
        @(negedge clk);
        check_idle("idle_after_done");
    endtask

    task automatic test_levready();
        int dc;
        run_frame(-1, 1'b0, dc);
        @(posedge clk); #1;
        start = 1'b0; lev_ready = 1'b0;
        @(negedge clk);
        check_idle("idle_after_ready_high");
        run_frame(20, 1'b0, dc);
        @(posedge clk); #1;
        start = 1'b0; lev_ready = 1'b0;
        @(negedge clk);
        check_idle("idle_after_ready_20");
    endtask

    task automatic test_start_held();
        int dc;
        run_frame(int'($urandom_range(1, 4)), 1'b1, dc);
        @(posedge clk); #1;
        lev_ready = 1'b0;
        @(negedge clk);
        check_idle("held_start_idle_gap");
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if ({busy, mac_clr} !== 2'b11) begin
            n_err++;
            $display("FAIL held_start_restart: got busy,clr=%b want 11", {busy, mac_clr});
        end
        start = 1'b0;
        #2 reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("idle_after_cleanup_reset");
    endtask

    task automatic test_reset_mid();
        int dc, target, bad;
        target = lag_base(1) + 3;
        start = 1'b1; lev_ready = 1'b0;
        for (int c = 1; c <= target; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_busy: got %b want 1", busy);
        end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, mac_clr, mac_en, r_we, r_wsel, lev_start, x_addr_a, x_addr_b} !== '0) begin
            n_err++;
            $display("FAIL mid_reset_async: got %b want all zero",
                     {busy, done, mac_clr, mac_en, r_we, r_wsel, lev_start, x_addr_a, x_addr_b});
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if ({busy, r_we, lev_start, done} !== 4'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL post_reset_quiet: got %0d active cycles want 0", bad);
        end
        run_frame(int'($urandom_range(1, 6)), 1'b0, dc);
        @(posedge clk); #1;
        start = 1'b0; lev_ready = 1'b0;
        @(negedge clk);
        check_idle("idle_after_restart");
    endtask

`ifdef AUTOCORR_ABORT_EN
    task automatic test_abort();
        int abort_c, bad;
        abort_c = lag_base(0) + FRAME_LEN + int'($urandom_range(1, PIPE_LAT));
        start = 1'b1; lev_ready = 1'b1;
        for (int c = 1; c <= abort_c; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            abort = (c == abort_c);
            @(negedge clk);
        end
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            if ({busy, r_we, lev_start, done, mac_en} !== 5'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL abort_drain: got %0d active cycles want 0", bad);
        end
        lev_ready = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_frame_basic();
        test_levready();
        test_start_held();
        test_reset_mid();
`ifdef AUTOCORR_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
